// File: rtl/program_loader.sv
// Boot loader: takes a byte stream (2-byte word count, then MSB-first words),
// writes the words to instruction memory and holds the CPU in reset until done.
module program_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        LOAD,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic [CNT_WIDTH-1:0]  word_idx_reg;
    logic [1:0]            byte_idx_reg;
    logic [31:0]           addr_reg;
    logic [31:0]           wdata_reg;
    logic                  cpu_reset_reg;
    logic                  done_reg;
    logic                  error_reg;

    logic [CNT_WIDTH-1:0]  hdr_count;
    logic [31:0]           hdr_count_ext;
    logic                  hdr_bad;
    logic                  load_xfer;
    logic                  last_word;

    // The low header byte is still on in_data when the count is validated.
    assign hdr_count     = {count_reg[CNT_WIDTH-1:8], in_data};
    assign hdr_count_ext = {{(32-CNT_WIDTH){1'b0}}, hdr_count};
    assign hdr_bad       = (hdr_count == '0) || (hdr_count_ext > MAX_W32);
    assign load_xfer     = (state_reg == LOAD) && in_valid;
    assign last_word     = ((word_idx_reg + CNT_WIDTH'(1)) == count_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= HDR_HI;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = HDR_LO;
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = hdr_bad ? ERROR : LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (byte_idx_reg == 2'd3)) state_next = WRITE;
            end
            WRITE:   state_next = last_word ? DONE : LOAD;
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = HDR_HI;
        endcase
    end

    // First three bytes of a word sit in per-lane registers; the fourth
    // byte goes straight into the output word together with them.
    for (genvar gi = 0; gi < 3; gi++) begin : gen_lane
        logic [7:0] lane_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                lane_reg <= 8'h00;
            end else if (load_xfer && (byte_idx_reg == 2'(gi))) begin
                lane_reg <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg     <= '0;
            word_idx_reg  <= '0;
            byte_idx_reg  <= 2'd0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            cpu_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            if ((state_reg == HDR_HI) && in_valid) begin
                count_reg[CNT_WIDTH-1:8] <= in_data;
            end
            if ((state_reg == HDR_LO) && in_valid) begin
                count_reg[7:0] <= in_data;
            end
            if (load_xfer) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                if (byte_idx_reg == 2'd3) begin
                    // Address and data are latched here so they hold after the write.
                    addr_reg  <= {{(30-CNT_WIDTH){1'b0}}, word_idx_reg, 2'b00};
                    wdata_reg <= {gen_lane[0].lane_reg, gen_lane[1].lane_reg,
                                  gen_lane[2].lane_reg, in_data};
                end
            end
            if (state_reg == WRITE) begin
                word_idx_reg <= word_idx_reg + CNT_WIDTH'(1);
                byte_idx_reg <= 2'd0;
            end
            done_reg      <= (state_next == DONE);
            cpu_reset_reg <= (state_next != DONE);
            error_reg     <= (state_next == ERROR);
        end
    end

    assign imem_we    = (state_reg == WRITE);
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign cpu_reset  = cpu_reset_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule
